io_host_port: RTL and testbench
===============================

# io_host_port

Host-side endpoint of the core IO handshake. It consumes the core's `io_output_ready` and `io_input_done` strobes and converts them to two byte-stream valid/ready channels for the host. Core-to-host bytes are buffered in a small FIFO. Host-to-core bytes are presented one at a time from a holding register. The block sits between the BXU core's IO op unit and the host transport, such as a UART or debug bridge.

## Interface
Parameters:
- `DATA_BITWIDTH`, 8, width of one IO word.
- `OFIFO_DEPTH`, 4, output FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `core_out_data`  in  DATA_BITWIDTH  core output word; valid while `io_output_ready` is high.
- `io_output_ready`  in  1  level from core; its rising edge means one new output word.
- `io_input_done`  in  1  level from core; its rising edge means the presented input word was consumed.
- `core_in_data`  out  DATA_BITWIDTH  word presented to the core.
- `core_in_valid`  out  1  `core_in_data` is valid.
- `host_tx_data`  in  DATA_BITWIDTH  host-to-core word.
- `host_tx_valid`  in  1  host offers `host_tx_data`.
- `host_tx_ready`  out  1  block accepts `host_tx_data`.
- `host_rx_data`  out  DATA_BITWIDTH  core-to-host word (FIFO head).
- `host_rx_valid`  out  1  FIFO not empty.
- `host_rx_ready`  in  1  host takes the head word.
- `ofifo_overflow`  out  1  sticky flag: an output word was dropped.
- `in_underrun`  out  1  sticky flag: done edge arrived with no word presented.

## Operation
- All inputs are synchronous to `clk`.
- Edge detect: the block registers `prev_out` and `prev_done`, reset 0.
  - `out_rise = io_output_ready & ~prev_out`.
  - `done_rise = io_input_done & ~prev_done`.
- Output path:
  - `out_rise` pushes `core_out_data` into the FIFO.
  - A push when full, with no simultaneous pop, drops the word and sets `ofifo_overflow`.
  - A pop occurs on `host_rx_valid & host_rx_ready`.
  - `host_rx_data` shows the head word while `host_rx_valid` is high.
  - Pointers are `log2(OFIFO_DEPTH)+1` bits; the extra MSB distinguishes full from empty. Pointers wrap modulo 2×depth.
- Input FSM has two states:
  - EMPTY: `host_tx_ready`=1, `core_in_valid`=0. When `host_tx_valid` is high, load `host_tx_data` into the holding register and go to LOADED.
  - LOADED: `host_tx_ready`=0, `core_in_valid`=1. On `done_rise`, go to EMPTY.
- `done_rise` in EMPTY has no state change and sets `in_underrun`.
- Sticky flags clear only on reset.

## Timing
- Reset values:
  - All outputs 0, except `host_tx_ready`=1 (FSM in EMPTY).
  - FIFO empty, edge registers 0.
  - `core_in_data` and `host_rx_data` read 0.
- Output latency:
  - The word is captured on the first `clk` edge at which `io_output_ready` is sampled high.
  - `host_rx_valid` rises the following cycle. There is no fall-through.
- A level held high for N cycles pushes exactly one word. A new push requires a low cycle first.
- Simultaneous push and pop:
  - FIFO full: both take effect; count unchanged; no overflow.
  - FIFO empty: push only.
- Input latency:
  - A handshake at edge k gives `core_in_valid`=1 from cycle k+1.
  - `done_rise` at edge m gives `core_in_valid`=0 and `host_tx_ready`=1 from cycle m+1.
  - Minimum period is 2 cycles per input word.
- Reset mid-operation discards the FIFO contents and the held word immediately, because reset is asynchronous.

## Structure
- Package `io_host_pkg` holds:
  - FSM state constants `ST_EMPTY`=1'b0 and `ST_LOADED`=1'b1.
  - An address-width function `clog2` for `OFIFO_DEPTH`.
- Sub-module `io_host_fifo` is a synchronous FIFO with push/pop/full/empty outputs and the same asynchronous reset. The top level holds the edge detectors, the FSM and the sticky flags.

## Test plan
- Output, single word: `core_out_data`=0xA5, `io_output_ready` high for 3 cycles, `host_rx_ready`=1 → exactly one word 0xA5 on `host_rx_data`, `host_rx_valid` high for 1 cycle starting the cycle after capture.
- Overflow: 5 output rises with data 0x01..0x05 and `host_rx_ready`=0 → `ofifo_overflow`=1; draining yields 0x01..0x04, then `host_rx_valid`=0.
- Full push+pop: FIFO full with 0x01..0x04; rise with 0x05 in the same cycle as a pop → no overflow; drain yields 0x02..0x05.
- Input handshake: `host_tx_data`=0x3C, `host_tx_valid`=1 → `core_in_valid`=1 next cycle with `core_in_data`=0x3C, `host_tx_ready`=0; a second host word is held off until `io_input_done` rises, then `host_tx_ready`=1 the next cycle.
- Underrun and reset: `io_input_done` rise while in EMPTY → `in_underrun`=1; assert `rst_n`=0 mid-transfer with 2 words queued → all outputs return to reset values asynchronously and the queued words are lost.

Source files
------------

// File: rtl/io_host_pkg.sv
// Shared types and helpers for the host-side IO endpoint.
package io_host_pkg;

    typedef enum logic {
        ST_EMPTY  = 1'b0,
        ST_LOADED = 1'b1
    } in_state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/io_host_fifo.sv
// Synchronous output FIFO; pointers carry one extra wrap bit to tell full from empty.
module io_host_fifo
    import io_host_pkg::*;
#(
    parameter int unsigned DATA_BITWIDTH = 8,
    parameter int unsigned DEPTH         = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_BITWIDTH-1:0] wr_data,
    output logic [DATA_BITWIDTH-1:0] rd_data,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [DATA_BITWIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            rd_ptr;
    logic                     wr_en;
    logic                     rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign wr_en = push & (~full | rd_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/io_host_port.sv
// Host-side endpoint: core IO strobes to host valid/ready byte channels.
module io_host_port
    import io_host_pkg::*;
#(
    parameter int unsigned DATA_BITWIDTH = 8,
    parameter int unsigned OFIFO_DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_BITWIDTH-1:0] core_out_data,
    input  logic                     io_output_ready,
    input  logic                     io_input_done,
    output logic [DATA_BITWIDTH-1:0] core_in_data,
    output logic                     core_in_valid,
    input  logic [DATA_BITWIDTH-1:0] host_tx_data,
    input  logic                     host_tx_valid,
    output logic                     host_tx_ready,
    output logic [DATA_BITWIDTH-1:0] host_rx_data,
    output logic                     host_rx_valid,
    input  logic                     host_rx_ready,
    output logic                     ofifo_overflow,
    output logic                     in_underrun
);

    logic      prev_out;
    logic      prev_done;
    logic      out_rise;
    logic      done_rise;
    logic      pop;
    logic      full;
    logic      empty;
    logic      load;
    in_state_t state;
    in_state_t state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_out  <= 1'b0;
            prev_done <= 1'b0;
        end else begin
            prev_out  <= io_output_ready;
            prev_done <= io_input_done;
        end
    end

    assign out_rise      = io_output_ready & ~prev_out;
    assign done_rise     = io_input_done & ~prev_done;
    assign host_rx_valid = ~empty;
    assign pop           = host_rx_valid & host_rx_ready;

    io_host_fifo #(
        .DATA_BITWIDTH(DATA_BITWIDTH),
        .DEPTH        (OFIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (out_rise),
        .pop    (pop),
        .wr_data(core_out_data),
        .rd_data(host_rx_data),
        .full   (full),
        .empty  (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_EMPTY;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY:  if (host_tx_valid) state_next = ST_LOADED;
            ST_LOADED: if (done_rise)     state_next = ST_EMPTY;
            default:                      state_next = ST_EMPTY;
        endcase
    end

    always_comb begin
        host_tx_ready = 1'b0;
        core_in_valid = 1'b0;
        case (state)
            ST_EMPTY:  host_tx_ready = 1'b1;
            ST_LOADED: core_in_valid = 1'b1;
            default:   host_tx_ready = 1'b0;
        endcase
    end

    assign load = host_tx_ready & host_tx_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_in_data   <= '0;
            ofifo_overflow <= 1'b0;
            in_underrun    <= 1'b0;
        end else begin
            if (load) core_in_data <= host_tx_data;
            if (out_rise & full & ~pop) ofifo_overflow <= 1'b1;
            if (done_rise & (state == ST_EMPTY)) in_underrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_io_host_port.sv
// Directed and randomized checks of io_host_port against a queue-based reference model.
module tb_io_host_port;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] core_out_data;
    logic       io_output_ready;
    logic       io_input_done;
    logic [7:0] core_in_data;
    logic       core_in_valid;
    logic [7:0] host_tx_data;
    logic       host_tx_valid;
    logic       host_tx_ready;
    logic [7:0] host_rx_data;
    logic       host_rx_valid;
    logic       host_rx_ready;
    logic       ofifo_overflow;
    logic       in_underrun;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mq[$];
    logic       m_prev_out;
    logic       m_prev_done;
    logic       m_loaded;
    logic [7:0] m_hold;
    logic       m_ovf;
    logic       m_unr;

    always #5 clk = ~clk;

    io_host_port #(
        .DATA_BITWIDTH(8),
        .OFIFO_DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .core_out_data  (core_out_data),
        .io_output_ready(io_output_ready),
        .io_input_done  (io_input_done),
        .core_in_data   (core_in_data),
        .core_in_valid  (core_in_valid),
        .host_tx_data   (host_tx_data),
        .host_tx_valid  (host_tx_valid),
        .host_tx_ready  (host_tx_ready),
        .host_rx_data   (host_rx_data),
        .host_rx_valid  (host_rx_valid),
        .host_rx_ready  (host_rx_ready),
        .ofifo_overflow (ofifo_overflow),
        .in_underrun    (in_underrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_prev_out  = 1'b0;
        m_prev_done = 1'b0;
        m_loaded    = 1'b0;
        m_hold      = 8'h00;
        m_ovf       = 1'b0;
        m_unr       = 1'b0;
    endtask

    // One clock edge worth of behaviour, from the inputs as they stand at the edge.
    task automatic model_edge();
        bit out_rise, done_rise, popped;
        out_rise  = io_output_ready && !m_prev_out;
        done_rise = io_input_done && !m_prev_done;
        m_prev_out  = io_output_ready;
        m_prev_done = io_input_done;
        popped = (mq.size() != 0) && host_rx_ready;
        if (popped) void'(mq.pop_front());
        if (out_rise) begin
            if (mq.size() < DEPTH) mq.push_back(core_out_data);
            else m_ovf = 1'b1;
        end
        if (!m_loaded) begin
            if (done_rise) m_unr = 1'b1;
            if (host_tx_valid) begin
                m_loaded = 1'b1;
                m_hold   = host_tx_data;
            end
        end else if (done_rise) begin
            m_loaded = 1'b0;
        end
    endtask

    task automatic check_all();
        check("rx_valid", host_rx_valid, mq.size() != 0);
        check("rx_data", host_rx_data, (mq.size() != 0) ? mq[0] : 8'h00);
        check("tx_ready", host_tx_ready, !m_loaded);
        check("in_valid", core_in_valid, m_loaded);
        if (m_loaded) check("in_data", core_in_data, m_hold);
        check("overflow", ofifo_overflow, m_ovf);
        check("underrun", in_underrun, m_unr);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_valid"}, host_rx_valid, 1'b0);
        check({tag, "_rx_data"}, host_rx_data, 8'h00);
        check({tag, "_tx_ready"}, host_tx_ready, 1'b1);
        check({tag, "_in_valid"}, core_in_valid, 1'b0);
        check({tag, "_in_data"}, core_in_data, 8'h00);
        check({tag, "_overflow"}, ofifo_overflow, 1'b0);
        check({tag, "_underrun"}, in_underrun, 1'b0);
    endtask

    // Inputs are changed only while clk is low; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push_word(input logic [7:0] d);
        core_out_data   = d;
        io_output_ready = 1'b1;
        tick();
        io_output_ready = 1'b0;
        tick();
    endtask

    initial begin
        int rx_cnt;
        rst_n           = 1'b0;
        core_out_data   = '0;
        io_output_ready = 1'b0;
        io_input_done   = 1'b0;
        host_tx_data    = '0;
        host_tx_valid   = 1'b0;
        host_rx_ready   = 1'b0;
        model_reset();
        #3 check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single word: level held three cycles yields exactly one word for one cycle.
        core_out_data   = 8'hA5;
        host_rx_ready   = 1'b1;
        io_output_ready = 1'b1;
        rx_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (host_rx_valid && host_rx_data == 8'hA5) rx_cnt++;
        end
        io_output_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (host_rx_valid) rx_cnt++;
        end
        check("single_word_count", rx_cnt, 1);

        // Overflow: five words into a four-entry FIFO, then drain.
        host_rx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push_word(i[7:0]);
        check("ovf_set", ofifo_overflow, 1'b1);
        host_rx_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("ovf_drain", host_rx_data, i);
            tick();
        end
        check("ovf_empty", host_rx_valid, 1'b0);
        host_rx_ready = 1'b0;

        // Full FIFO with simultaneous push and pop.
        apply_reset();
        for (int i = 1; i <= 4; i++) push_word(i[7:0]);
        core_out_data   = 8'h05;
        io_output_ready = 1'b1;
        host_rx_ready   = 1'b1;
        tick();
        io_output_ready = 1'b0;
        host_rx_ready   = 1'b0;
        check("fullpp_no_ovf", ofifo_overflow, 1'b0);
        host_rx_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            check("fullpp_drain", host_rx_data, i);
            tick();
        end
        host_rx_ready = 1'b0;

        // Input handshake, held-off second word, release on done edge.
        host_tx_data  = 8'h3C;
        host_tx_valid = 1'b1;
        tick();
        check("in_hs_data", core_in_data, 8'h3C);
        host_tx_data = 8'h77;
        tick();
        tick();
        check("in_holdoff", host_tx_ready, 1'b0);
        host_tx_valid = 1'b0;
        io_input_done = 1'b1;
        tick();
        check("in_release", host_tx_ready, 1'b1);
        io_input_done = 1'b0;
        tick();

        // Underrun: done edge with nothing presented.
        io_input_done = 1'b1;
        tick();
        check("underrun_set", in_underrun, 1'b1);
        io_input_done = 1'b0;
        tick();

        // Asynchronous reset with two words queued and a word presented.
        host_tx_data  = 8'h5A;
        host_tx_valid = 1'b1;
        push_word(8'h11);
        host_tx_valid = 1'b0;
        push_word(8'h22);
        apply_reset();
        tick();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) io_output_ready = ~io_output_ready;
            if ($urandom_range(0, 3) == 0) io_input_done = ~io_input_done;
            core_out_data = 8'($urandom);
            host_tx_data  = 8'($urandom);
            host_tx_valid = ($urandom_range(0, 2) == 0);
            host_rx_ready = (i % 400 < 200) ? ($urandom_range(0, 3) == 0)
                                            : ($urandom_range(0, 3) != 0);
            tick();
            if (i == 1500) apply_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
